ifu_fetch: RTL

- Instruction fetch stage directly upstream of the single-cycle execute core.
- Owns the fetch PC and issues 32-bit instruction reads to instruction memory over a valid/ready request plus in-order response interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the core through a valid/ready handshake.
- Accepts a redirect (jump/branch/trap target) that flushes buffered and in-flight fetches.

---
 rtl/ifu_pkg.sv | 29 ++
 rtl/ifu_fetch_fifo.sv | 65 ++++++
 rtl/ifu_fetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the address/instruction widths, the reset PC, the buffer and
// in-flight sizing, the counter widths derived from them, and the entry
// type stored in the instruction buffer.
package ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  // Instruction buffer entries (power of two, >= 1).
  localparam int FIFO_DEPTH = 2;
  // Maximum accepted-but-unanswered memory requests.
  localparam int MAX_OUTSTANDING = 2;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int FIFO_CNT_W = cnt_width(FIFO_DEPTH);
  localparam int OUT_CNT_W  = cnt_width(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// sync_fifo: small synchronous FIFO with flush and occupancy count.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (clears storage too,
//                so rdata reads zero straight out of reset)
//   flush        drop all entries this cycle (wins over push/pop)
//   push, wdata  write an entry; ignored when full unless a pop frees a slot
//   pop          remove the head entry; ignored when empty
//   rdata        head entry (show-ahead)
//   count        number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding the execute core.
// Owns the fetch PC, issues word reads to instruction memory, buffers the
// returned words with their PCs and hands them to the core. A redirect
// flushes the buffer and marks every in-flight fetch as stale.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   imem_req_valid/ready/addr           fetch request (word-aligned address)
//   imem_resp_valid/data                in-order response, always accepted
//   redirect_valid/redirect_pc          one-cycle redirect to a new target
//   inst_valid/ready, inst, inst_pc     instruction handed to the core
//
// Handshakes: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high; an instruction transfers on an edge where
// inst_valid and inst_ready are both high. imem_req_valid comes from a
// register and never depends combinationally on any input. Responses have
// no ready: a response with nothing outstanding is ignored.
module ifu_fetch
  import ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int SUM_W = ((FIFO_CNT_W > OUT_CNT_W) ? FIFO_CNT_W : OUT_CNT_W) + 1;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       fetch_pc_next;
  logic [OUT_CNT_W-1:0]  outstanding;
  logic [OUT_CNT_W-1:0]  outstanding_next;
  logic [OUT_CNT_W-1:0]  drop_count;
  logic [OUT_CNT_W-1:0]  drop_count_next;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W-1:0] fifo_count_next;
  logic                  req_valid_q;
  logic                  req_valid_next;
  logic                  req_fire;
  logic                  resp_fire;
  logic                  resp_keep;
  logic                  inst_pop;
  logic [XLEN-1:0]       inflight_pc;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign req_fire  = req_valid_q && imem_req_ready;
  assign resp_fire = imem_resp_valid && (outstanding != '0);
  // A response is stale if older redirects still owe drops, or if it lands
  // in the redirect cycle itself.
  assign resp_keep = resp_fire && !redirect_valid && (drop_count == '0);
  assign inst_pop  = inst_valid && inst_ready && !redirect_valid;

  assign push_entry.inst = imem_resp_data;
  assign push_entry.pc   = inflight_pc;

  // In-flight PC queue: one entry per accepted request, popped by every
  // response (stale or not). Its occupancy is the outstanding count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (OUT_CNT_W)
  ) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (resp_fire),
    .rdata (inflight_pc),
    .count (outstanding)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH),
    .CW    (FIFO_CNT_W)
  ) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (resp_keep),
    .wdata (push_entry),
    .pop   (inst_pop),
    .rdata (head_entry),
    .count (fifo_count)
  );

  always_comb begin
    outstanding_next = outstanding + OUT_CNT_W'(req_fire) - OUT_CNT_W'(resp_fire);
    fifo_count_next  = fifo_count + FIFO_CNT_W'(resp_keep) - FIFO_CNT_W'(inst_pop);
    drop_count_next  = drop_count;
    fetch_pc_next    = fetch_pc;

    if (req_fire) fetch_pc_next = fetch_pc + XLEN'(4);

    if (redirect_valid) begin
      fetch_pc_next   = redirect_pc & WORD_MASK;
      fifo_count_next = '0;
      // Everything still in flight after this edge, including a request
      // firing right now, belongs to the old path. drop_count never exceeds
      // outstanding, so the in-flight total is the new stale count.
      drop_count_next = outstanding_next;
    end else if (resp_fire && (drop_count != '0)) begin
      drop_count_next = drop_count - OUT_CNT_W'(1);
    end

    // Credit is evaluated on the post-edge state so the request valid can
    // be registered and still reflect the state it is presented with.
    req_valid_next = ((SUM_W'(outstanding_next) + SUM_W'(fifo_count_next)) < SUM_W'(FIFO_DEPTH))
                     && (outstanding_next < OUT_CNT_W'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      drop_count  <= '0;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      drop_count  <= drop_count_next;
      req_valid_q <= req_valid_next;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc & WORD_MASK;
  assign inst_valid     = (fifo_count != '0);
  assign inst           = head_entry.inst;
  assign inst_pc        = head_entry.pc;

endmodule
